// File: rtl/lpc_cycle_serializer.sv
// Buffers 32-bit LPC cycle records in a FIFO and replays each one as a framed
// 5-byte stream (sync, addr hi, addr lo, data, type) on a valid/ready byte port.
module lpc_cycle_serializer #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'h55
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic [31:0]           tdata_i,
  input  logic                  ready_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  input  logic                  clr_ovf_i,
  output logic                  overflow_o,
  output logic [7:0]            drop_cnt_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_AHI,
    S_ALO,
    S_DAT,
    S_TYP
  } state_e;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  state_e                state_q;
  logic [31:0]           shadow_q;
  logic [7:0]            byte_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic [7:0]            drop_q;

  logic handshake, fifo_empty, fifo_full, pop, push, drop;

  assign handshake  = valid_q & byte_ready_i;
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == FULL_LEVEL);
  // A pop frees a slot on the same edge, so a push into a full FIFO is still accepted.
  assign pop  = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_TYP && handshake));
  assign push = ready_i && (!fifo_full || pop);
  assign drop = ready_i && fifo_full && !pop;

  // NOTE: the record storage carries no reset; pointers and level alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (clr_ovf_i) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
    end else if (pop) begin
      state_q  <= S_SYNC;
      shadow_q <= mem_q[rd_ptr_q];
      byte_q   <= SYNC_BYTE;
      valid_q  <= 1'b1;
    end else if (handshake) begin
      unique case (state_q)
        S_SYNC: begin state_q <= S_AHI; byte_q <= shadow_q[31:24]; end
        S_AHI:  begin state_q <= S_ALO; byte_q <= shadow_q[23:16]; end
        S_ALO:  begin state_q <= S_DAT; byte_q <= shadow_q[15:8];  end
        S_DAT:  begin state_q <= S_TYP; byte_q <= shadow_q[7:0];   end
        default: begin
          state_q <= S_IDLE;
          byte_q  <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;
  assign level_o      = level_q;

endmodule

// File: tb/tb_lpc_cycle_serializer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// clock against a queue-based reference of the record FIFO and frame output.
module tb_lpc_cycle_serializer;

  localparam int         DL = 4;
  localparam int         D  = 1 << DL;
  localparam logic [7:0] SB = 8'h55;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] tdata;
  logic        ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        clr_ovf;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [DL:0] level;

  lpc_cycle_serializer #(.DEPTH_LOG2(DL), .SYNC_BYTE(SB)) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .tdata_i      (tdata),
    .ready_i      (ready),
    .byte_o       (byte_out),
    .byte_valid_o (byte_valid),
    .byte_ready_i (byte_ready),
    .clr_ovf_i    (clr_ovf),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt),
    .level_o      (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: queued records, bytes still owed for the frame in flight, its record.
  logic [31:0] m_q[$];
  int          m_rem;
  logic [31:0] m_sh;
  bit          m_ovf;
  int          m_drop;
  logic [7:0]  got[$];
  int          max_lvl;

  function automatic logic [7:0] m_byte();
    case (m_rem)
      5:       return SB;
      4:       return m_sh[31:24];
      3:       return m_sh[23:16];
      2:       return m_sh[15:8];
      default: return m_sh[7:0];
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rem  = 0;
    m_sh   = '0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  task automatic model_edge();
    int  size_before;
    bit  hs, pop, dropped;
    size_before = m_q.size();
    hs  = (m_rem > 0) && byte_ready;
    pop = (size_before > 0) && ((m_rem == 0) || (hs && m_rem == 1));
    if (hs) m_rem--;
    if (pop) begin
      m_sh  = m_q.pop_front();
      m_rem = 5;
    end
    dropped = 0;
    if (ready) begin
      if (size_before < D || pop) m_q.push_back(tdata);
      else dropped = 1;
    end
    if (clr_ovf) begin
      m_ovf  = 0;
      m_drop = 0;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  // Inputs are final when this is entered (at a falling edge).
  task automatic cycle();
    if (byte_valid && byte_ready) got.push_back(byte_out);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("valid", byte_valid, (m_rem > 0));
    check("level", level, m_q.size());
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
    if (m_rem > 0) check("byte", byte_out, m_byte());
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  task automatic strobe(input logic [31:0] rec);
    ready = 1'b1;
    tdata = rec;
    cycle();
    ready = 1'b0;
  endtask

  task automatic expect_recs(input logic [31:0] recs[$]);
    logic [7:0] exp[$];
    int n;
    foreach (recs[i]) begin
      exp.push_back(SB);
      exp.push_back(recs[i][31:24]);
      exp.push_back(recs[i][23:16]);
      exp.push_back(recs[i][15:8]);
      exp.push_back(recs[i][7:0]);
    end
    check("stream_len", got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("stream[%0d]", i), got[i], exp[i]);
    got.delete();
  endtask

  function automatic logic [31:0] rand_rec();
    logic [31:0] r;
    r = $urandom;
    r[7:2] = '0;
    return r;
  endfunction

  initial begin
    logic [31:0] recs[$];
    nrst = 1'b0; tdata = '0; ready = 1'b0; byte_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    max_lvl = 0;
    repeat (2) @(negedge clk);
    check("rst_byte", byte_out, 8'h00);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_drop", drop_cnt, 8'h00);
    check("rst_level", level, 0);
    nrst = 1'b1;

    // Single record
    byte_ready = 1'b1;
    strobe(32'hF0F05A01);
    repeat (8) cycle();
    recs = '{32'hF0F05A01};
    expect_recs(recs);
    check("single_level_end", level, 0);

    // Backpressure, ready alternating
    strobe(32'hF0F05A01);
    for (int i = 0; i < 16; i++) begin
      byte_ready = (i % 2 == 0);
      cycle();
    end
    byte_ready = 1'b1;
    repeat (4) cycle();
    expect_recs(recs);

    // Back-to-back strobes
    max_lvl = 0;
    strobe(32'h0000BB01);
    strobe(32'h0001BC02);
    strobe(32'h0002BD03);
    repeat (18) cycle();
    recs = '{32'h0000BB01, 32'h0001BC02, 32'h0002BD03};
    expect_recs(recs);
    check("b2b_max_level", max_lvl, 2);

    // Overflow: sink stalled, 18 strobes
    byte_ready = 1'b0;
    recs.delete();
    for (int i = 0; i < 18; i++) begin
      logic [31:0] r;
      r = rand_rec();
      if (i < 17) recs.push_back(r);
      strobe(r);
    end
    cycle();
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop", drop_cnt, 8'd1);
    check("ovf_level", level, D);
    clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
    check("clr_flag", overflow, 1'b0);
    check("clr_drop", drop_cnt, 8'd0);
    // Drop and clear on the same edge: clear wins
    clr_ovf = 1'b1; strobe(rand_rec()); clr_ovf = 1'b0;
    check("clr_vs_drop_flag", overflow, 1'b0);
    check("clr_vs_drop_cnt", drop_cnt, 8'd0);
    // Saturation
    ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tdata = rand_rec();
      cycle();
    end
    ready = 1'b0;
    check("drop_saturate", drop_cnt, 8'd255);
    clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
    byte_ready = 1'b1;
    repeat (17 * 5 + 5) cycle();
    expect_recs(recs);

    // Pointer wrap: 40 records, one every 6 clocks
    recs.delete();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = rand_rec();
      recs.push_back(r);
      strobe(r);
      repeat (5) cycle();
    end
    repeat (8) cycle();
    expect_recs(recs);
    check("wrap_no_ovf", overflow, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ready      = ($urandom_range(2) == 0);
      tdata      = rand_rec();
      byte_ready = ($urandom_range(3) != 0);
      clr_ovf    = ($urandom_range(63) == 0);
      cycle();
    end
    ready = 1'b0; clr_ovf = 1'b0; byte_ready = 1'b1;
    repeat (5 * (D + 2)) cycle();
    check("rand_drained", level, 0);
    got.delete();

    // Reset mid-frame with 3 records queued
    byte_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(rand_rec());
    byte_ready = 1'b1;
    repeat (3) cycle();
    byte_ready = 1'b0;
    #2 nrst = 1'b0;
    #1;
    check("midrst_byte", byte_out, 8'h00);
    check("midrst_valid", byte_valid, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_drop", drop_cnt, 8'h00);
    check("midrst_level", level, 0);
    model_reset();
    got.delete();
    @(negedge clk);
    nrst = 1'b1;
    byte_ready = 1'b1;
    repeat (10) cycle();
    check("midrst_silent", got.size(), 0);
    recs = '{32'h1234AB03};
    strobe(32'h1234AB03);
    repeat (8) cycle();
    expect_recs(recs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
